// File: rtl/io_port_bridge.sv
// io_port_bridge: device-side counterpart of the processor's I/O pins.
//
// Host words are buffered in an input FIFO whose head is presented on in_port.
// A rate-limited interrupt pulse is raised while input data is waiting. Words the
// processor writes on out_port are captured in an output FIFO that the host drains.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   host_in_*         host -> input FIFO push (valid/ready/data)
//   in_port           head of input FIFO (0 when empty)
//   cpu_in_rd         processor consumed in_port (pops input FIFO)
//   irq_en            interrupt generation enable
//   interrupt         one-cycle pulse, at least HOLDOFF+1 low cycles between pulses
//   out_port          processor output word
//   cpu_out_wr        out_port valid this cycle (pushes output FIFO)
//   host_out_*        output FIFO head to host (valid/data/ready)
//   out_ovf           sticky output-word-dropped flag
//   in_count          input FIFO occupancy
//   drop_cnt          saturating dropped-word counter (only with IO_DROP_CNT_EN)
//
// Optional feature macro: IO_DROP_CNT_EN
module io_port_bridge #(
    parameter int unsigned W         = 16,
    parameter int unsigned IN_DEPTH  = 4,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned HOLDOFF   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      host_in_valid,
    input  logic [W-1:0]              host_in_data,
    output logic                      host_in_ready,
    output logic [W-1:0]              in_port,
    input  logic                      cpu_in_rd,
    input  logic                      irq_en,
    output logic                      interrupt,
    input  logic [W-1:0]              out_port,
    input  logic                      cpu_out_wr,
    output logic                      host_out_valid,
    output logic [W-1:0]              host_out_data,
    input  logic                      host_out_ready,
    output logic                      out_ovf,
    output logic [$clog2(IN_DEPTH):0] in_count
`ifdef IO_DROP_CNT_EN
    ,
    output logic [15:0]               drop_cnt
`endif
);

    localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
    localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
    localparam int unsigned HCW    = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } irq_state_e;

    // ---------------- Input FIFO ----------------
    logic [W-1:0]   in_mem_q [IN_DEPTH];
    logic [IN_AW:0] in_wr_q;
    logic [IN_AW:0] in_rd_q;
    logic [IN_AW:0] in_count_q;
    logic           in_empty;
    logic           in_full;
    logic           in_push;
    logic           in_pop;

    assign in_empty = (in_wr_q == in_rd_q);
    assign in_full  = (in_wr_q[IN_AW] != in_rd_q[IN_AW]) &&
                      (in_wr_q[IN_AW-1:0] == in_rd_q[IN_AW-1:0]);

    // Held low during reset so the host cannot push into a FIFO being cleared.
    assign host_in_ready = !in_full && !rst;
    assign in_push       = host_in_valid && host_in_ready;
    assign in_pop        = cpu_in_rd && !in_empty;

    // Input FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            in_wr_q    <= '0;
            in_rd_q    <= '0;
            in_count_q <= '0;
        end else begin
            if (in_push) in_wr_q <= in_wr_q + (IN_AW+1)'(1);
            if (in_pop)  in_rd_q <= in_rd_q + (IN_AW+1)'(1);
            case ({in_push, in_pop})
                2'b10:   in_count_q <= in_count_q + (IN_AW+1)'(1);
                2'b01:   in_count_q <= in_count_q - (IN_AW+1)'(1);
                default: in_count_q <= in_count_q;
            endcase
        end
    end

    // Input FIFO storage (data only, no reset needed: reads gated by empty)
    always_ff @(posedge clk) begin
        if (in_push) in_mem_q[in_wr_q[IN_AW-1:0]] <= host_in_data;
    end

    assign in_port  = in_empty ? '0 : in_mem_q[in_rd_q[IN_AW-1:0]];
    assign in_count = in_count_q;

    // ---------------- Interrupt FSM ----------------
    irq_state_e     state_q;
    irq_state_e     state_d;
    logic [HCW-1:0] hold_q;
    logic [HCW-1:0] hold_d;

    // State and hold-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state: once a pulse fires the full PULSE+HOLD sequence always completes
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (irq_en && (in_count_q != '0)) state_d = PULSE;
            end
            PULSE: begin
                hold_d  = HCW'(HOLDOFF - 1);
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_q == '0) state_d = IDLE;
                else              hold_d  = hold_q - HCW'(1);
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    assign interrupt = (state_q == PULSE);

    // ---------------- Output FIFO ----------------
    logic [W-1:0]    out_mem_q [OUT_DEPTH];
    logic [OUT_AW:0] out_wr_q;
    logic [OUT_AW:0] out_rd_q;
    logic            out_ovf_q;
    logic            out_empty;
    logic            out_full;
    logic            out_push;
    logic            out_pop;
    logic            out_drop;

    assign out_empty = (out_wr_q == out_rd_q);
    assign out_full  = (out_wr_q[OUT_AW] != out_rd_q[OUT_AW]) &&
                       (out_wr_q[OUT_AW-1:0] == out_rd_q[OUT_AW-1:0]);

    // A full FIFO still accepts a word when the host frees a slot in the same cycle.
    assign out_push = cpu_out_wr && (!out_full || host_out_ready);
    assign out_pop  = host_out_ready && !out_empty;
    assign out_drop = cpu_out_wr && !out_push;

    // Output FIFO pointers and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            if (out_push) out_wr_q <= out_wr_q + (OUT_AW+1)'(1);
            if (out_pop)  out_rd_q <= out_rd_q + (OUT_AW+1)'(1);
            if (out_drop) out_ovf_q <= 1'b1;
        end
    end

    // Output FIFO storage
    always_ff @(posedge clk) begin
        if (out_push) out_mem_q[out_wr_q[OUT_AW-1:0]] <= out_port;
    end

    assign host_out_valid = !out_empty;
    assign host_out_data  = out_empty ? '0 : out_mem_q[out_rd_q[OUT_AW-1:0]];
    assign out_ovf        = out_ovf_q;

`ifdef IO_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    // Saturating count of dropped output words
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (out_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_io_port_bridge.sv
// Bench for io_port_bridge: table of per-cycle vectors plus hand sequences for
// interrupt spacing, irq_en clear mid-hold, reset-release ready, and mid-operation reset.
module tb_io_port_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_in_valid;
    logic [15:0] host_in_data;
    logic        host_in_ready;
    logic [15:0] in_port;
    logic        cpu_in_rd;
    logic        irq_en;
    logic        interrupt;
    logic [15:0] out_port;
    logic        cpu_out_wr;
    logic        host_out_valid;
    logic [15:0] host_out_data;
    logic        host_out_ready;
    logic        out_ovf;
    logic [2:0]  in_count;
`ifdef IO_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    io_port_bridge #(.W(16), .IN_DEPTH(4), .OUT_DEPTH(4), .HOLDOFF(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .host_in_valid  (host_in_valid),
        .host_in_data   (host_in_data),
        .host_in_ready  (host_in_ready),
        .in_port        (in_port),
        .cpu_in_rd      (cpu_in_rd),
        .irq_en         (irq_en),
        .interrupt      (interrupt),
        .out_port       (out_port),
        .cpu_out_wr     (cpu_out_wr),
        .host_out_valid (host_out_valid),
        .host_out_data  (host_out_data),
        .host_out_ready (host_out_ready),
        .out_ovf        (out_ovf),
        .in_count       (in_count)
`ifdef IO_DROP_CNT_EN
        ,
        .drop_cnt       (drop_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        hiv;
        logic [15:0] hid;
        logic        rd;
        logic        irq;
        logic [15:0] op;
        logic        ow;
        logic        hor;
        logic        hir;
        logic [15:0] inp;
        logic [2:0]  cnt;
        logic        intr;
        logic        hov;
        logic [15:0] hod;
        logic        ovf;
        logic [15:0] drop;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic r, input logic hiv, input logic [15:0] hid,
                     input logic rd, input logic irq, input logic [15:0] op,
                     input logic ow, input logic hor,
                     input logic hir, input logic [15:0] inp, input logic [2:0] cnt,
                     input logic intr, input logic hov, input logic [15:0] hod,
                     input logic ovf, input logic [15:0] drop);
        vec_t e;
        e.rst = r; e.hiv = hiv; e.hid = hid; e.rd = rd; e.irq = irq;
        e.op = op; e.ow = ow; e.hor = hor;
        e.hir = hir; e.inp = inp; e.cnt = cnt; e.intr = intr;
        e.hov = hov; e.hod = hod; e.ovf = ovf; e.drop = drop;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic hiv, input logic [15:0] hid,
                         input logic rd, input logic irq, input logic [15:0] op,
                         input logic ow, input logic hor);
        rst = r; host_in_valid = hiv; host_in_data = hid; cpu_in_rd = rd;
        irq_en = irq; out_port = op; cpu_out_wr = ow; host_out_ready = hor;
    endtask

    // Apply current inputs across one edge, then sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    task automatic idle(input logic irq);
        drive(1'b0, 1'b0, 16'h0, 1'b0, irq, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

        //  rst hiv hid      rd irq op       ow hor | hir inp      cnt intr hov hod      ovf drop
        v(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
        v(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0,   1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
        // single push, interrupt one edge after in_count becomes 1
        v(0, 1, 16'hA5A5, 0, 1, 16'h0000, 0, 0,   1, 16'hA5A5, 1, 0, 0, 16'h0000, 0, 0);
        v(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0,   1, 16'hA5A5, 1, 1, 0, 16'h0000, 0, 0);
        v(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0,   1, 16'hA5A5, 1, 0, 0, 16'h0000, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0,   1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0,   1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
        // five pushes into a 4-deep FIFO
        v(0, 1, 16'h0001, 0, 0, 16'h0000, 0, 0,   1, 16'h0001, 1, 0, 0, 16'h0000, 0, 0);
        v(0, 1, 16'h0002, 0, 0, 16'h0000, 0, 0,   1, 16'h0001, 2, 0, 0, 16'h0000, 0, 0);
        v(0, 1, 16'h0003, 0, 0, 16'h0000, 0, 0,   1, 16'h0001, 3, 0, 0, 16'h0000, 0, 0);
        v(0, 1, 16'h0004, 0, 0, 16'h0000, 0, 0,   0, 16'h0001, 4, 0, 0, 16'h0000, 0, 0);
        v(0, 1, 16'h0005, 0, 0, 16'h0000, 0, 0,   0, 16'h0001, 4, 0, 0, 16'h0000, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0,   1, 16'h0002, 3, 0, 0, 16'h0000, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0,   1, 16'h0003, 2, 0, 0, 16'h0000, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0,   1, 16'h0004, 1, 0, 0, 16'h0000, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0,   1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
        // simultaneous push/pop, and push+pop while empty
        v(0, 1, 16'h0007, 0, 0, 16'h0000, 0, 0,   1, 16'h0007, 1, 0, 0, 16'h0000, 0, 0);
        v(0, 1, 16'h0008, 1, 0, 16'h0000, 0, 0,   1, 16'h0008, 1, 0, 0, 16'h0000, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0,   1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
        v(0, 1, 16'h0009, 1, 0, 16'h0000, 0, 0,   1, 16'h0009, 1, 0, 0, 16'h0000, 0, 0);
        v(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0,   1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
        // output FIFO fill, overflow drop, drain
        v(0, 0, 16'h0000, 0, 0, 16'h0001, 1, 0,   1, 16'h0000, 0, 0, 1, 16'h0001, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 16'h0002, 1, 0,   1, 16'h0000, 0, 0, 1, 16'h0001, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 16'h0003, 1, 0,   1, 16'h0000, 0, 0, 1, 16'h0001, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 16'h0004, 1, 0,   1, 16'h0000, 0, 0, 1, 16'h0001, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 16'h0005, 1, 0,   1, 16'h0000, 0, 0, 1, 16'h0001, 1, 1);
        v(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 0, 1, 16'h0002, 1, 1);
        v(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 0, 1, 16'h0003, 1, 1);
        v(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 0, 1, 16'h0004, 1, 1);
        v(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 0, 0, 16'h0000, 1, 1);
        v(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 0, 0, 16'h0000, 1, 1);
        // reset clears ovf; full FIFO write with same-cycle pop is not a drop
        v(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,   1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 16'h0011, 1, 0,   1, 16'h0000, 0, 0, 1, 16'h0011, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 16'h0012, 1, 0,   1, 16'h0000, 0, 0, 1, 16'h0011, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 16'h0013, 1, 0,   1, 16'h0000, 0, 0, 1, 16'h0011, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 16'h0014, 1, 0,   1, 16'h0000, 0, 0, 1, 16'h0011, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 16'h0015, 1, 1,   1, 16'h0000, 0, 0, 1, 16'h0012, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 0, 1, 16'h0013, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 0, 1, 16'h0014, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 0, 1, 16'h0015, 0, 0);
        v(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,   1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].hiv, vecs[i].hid, vecs[i].rd, vecs[i].irq,
                  vecs[i].op, vecs[i].ow, vecs[i].hor);
            tick();
            chk($sformatf("v%0d.host_in_ready", i), 32'(host_in_ready), 32'(vecs[i].hir));
            chk($sformatf("v%0d.in_port", i), 32'(in_port), 32'(vecs[i].inp));
            chk($sformatf("v%0d.in_count", i), 32'(in_count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d.interrupt", i), 32'(interrupt), 32'(vecs[i].intr));
            chk($sformatf("v%0d.host_out_valid", i), 32'(host_out_valid), 32'(vecs[i].hov));
            chk($sformatf("v%0d.host_out_data", i), 32'(host_out_data), 32'(vecs[i].hod));
            chk($sformatf("v%0d.out_ovf", i), 32'(out_ovf), 32'(vecs[i].ovf));
`ifdef IO_DROP_CNT_EN
            chk($sformatf("v%0d.drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].drop));
`endif
        end

        // Ready rises in the first cycle after reset falls, before any edge.
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        chk("rst_hold.host_in_ready", 32'(host_in_ready), 32'd0);
        rst = 1'b0;
        #1;
        n_vec++;
        chk("rst_release.host_in_ready", 32'(host_in_ready), 32'd1);

        // Pulse spacing with a persistently non-empty FIFO, then irq_en cleared mid-hold.
        drive(1'b0, 1'b1, 16'h00C3, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
        tick();
        chk("spacing.push_count", 32'(in_count), 32'd1);
        for (int i = 1; i <= 60; i++) begin
            idle(i <= 32);
            tick();
            // pulses at 1, 11, 21, 31: one high cycle then nine low cycles
            chk($sformatf("spacing.interrupt[%0d]", i), 32'(interrupt),
                32'((i <= 32) && (i % 10 == 1)));
        end
        chk("spacing.word_kept", 32'(in_port), 32'h00C3);

        // Reset with both FIFOs holding data, overflow set, and the FSM in HOLD.
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 16'h1111, 1'b0, 1'b1, 16'h0021, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0022, 1'b1, 1'b0);
        tick();
        chk("midrst.pulse", 32'(interrupt), 32'd1);
        out_port = 16'h0023;
        tick();
        out_port = 16'h0024;
        tick();
        out_port = 16'h0025;
        tick();
        chk("midrst.pre_ovf", 32'(out_ovf), 32'd1);
        chk("midrst.pre_in_count", 32'(in_count), 32'd1);
        chk("midrst.pre_out_data", 32'(host_out_data), 32'h0021);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
        tick();
        chk("midrst.interrupt", 32'(interrupt), 32'd0);
        chk("midrst.in_port", 32'(in_port), 32'd0);
        chk("midrst.in_count", 32'(in_count), 32'd0);
        chk("midrst.host_out_valid", 32'(host_out_valid), 32'd0);
        chk("midrst.host_out_data", 32'(host_out_data), 32'd0);
        chk("midrst.out_ovf", 32'(out_ovf), 32'd0);
        chk("midrst.host_in_ready", 32'(host_in_ready), 32'd0);
`ifdef IO_DROP_CNT_EN
        chk("midrst.drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        for (int i = 0; i < 12; i++) begin
            idle(1'b1);
            tick();
            chk($sformatf("postrst.interrupt[%0d]", i), 32'(interrupt), 32'd0);
            chk($sformatf("postrst.in_count[%0d]", i), 32'(in_count), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
